// File: rtl/network_pkg.sv
// Shared 5-tuple packet and range-rule types used by the classifier matchers.
// Field-hit index constants give every consumer the same bit order.
package network_pkg;

  localparam int PKT_W  = 104;
  localparam int RULE_W = 240;

  typedef struct packed {
    logic [31:0] ip;
    logic [15:0] port;
  } endpoint_s;

  typedef struct packed {
    endpoint_s   src;
    endpoint_s   dst;
    logic [7:0]  protocol;
  } packet_s;

  typedef struct packed {
    packet_s     first;
    packet_s     last;
    logic [31:0] weight;
  } rule_s;

  localparam int FH_SRC_IP   = 0;
  localparam int FH_SRC_PORT = 1;
  localparam int FH_DST_IP   = 2;
  localparam int FH_DST_PORT = 3;
  localparam int FH_PROTO    = 4;
  localparam int FH_COUNT    = 5;

endpackage

// File: rtl/field_range_cmp.sv
// Inclusive unsigned range test for one header field: lo <= value <= hi.
// A degenerate range (lo > hi) simply never hits.
module field_range_cmp #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] value,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] hi,
  output logic             hit
);

  assign hit = (lo <= value) && (value <= hi);

endmodule

// File: rtl/rule_matcher.sv
// Matches one 5-tuple packet against one range rule: a combinational result for
// same-cycle tree walking plus a registered, valid-qualified copy.
module rule_matcher
  import network_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic [RULE_W-1:0]    rule,
  input  logic [PKT_W-1:0]     packet,
  input  logic                 in_valid,
  output logic                 matched,
  output logic [FH_COUNT-1:0]  field_hits,
  output logic                 out_valid,
  output logic                 matched_q,
  output logic [FH_COUNT-1:0]  field_hits_q
);

  packet_s              w_first;
  packet_s              w_last;
  packet_s              w_pkt;
  logic [FH_COUNT-1:0]  w_field_hits;
  logic                 w_matched;
  logic                 w_unused_weight;

  logic                 r_out_valid;
  logic                 r_matched_q;
  logic [FH_COUNT-1:0]  r_field_hits_q;

  assign w_first = rule[RULE_W-1 -: PKT_W];
  assign w_last  = rule[RULE_W-PKT_W-1 -: PKT_W];
  assign w_pkt   = packet;
  // Priority is resolved by the caller; this block only decides hit/miss.
  assign w_unused_weight = ^rule[31:0];

  field_range_cmp #(.WIDTH(32)) u_cmp_src_ip (
    .value (w_pkt.src.ip),
    .lo    (w_first.src.ip),
    .hi    (w_last.src.ip),
    .hit   (w_field_hits[FH_SRC_IP])
  );

  field_range_cmp #(.WIDTH(16)) u_cmp_src_port (
    .value (w_pkt.src.port),
    .lo    (w_first.src.port),
    .hi    (w_last.src.port),
    .hit   (w_field_hits[FH_SRC_PORT])
  );

  field_range_cmp #(.WIDTH(32)) u_cmp_dst_ip (
    .value (w_pkt.dst.ip),
    .lo    (w_first.dst.ip),
    .hi    (w_last.dst.ip),
    .hit   (w_field_hits[FH_DST_IP])
  );

  field_range_cmp #(.WIDTH(16)) u_cmp_dst_port (
    .value (w_pkt.dst.port),
    .lo    (w_first.dst.port),
    .hi    (w_last.dst.port),
    .hit   (w_field_hits[FH_DST_PORT])
  );

  field_range_cmp #(.WIDTH(8)) u_cmp_proto (
    .value (w_pkt.protocol),
    .lo    (w_first.protocol),
    .hi    (w_last.protocol),
    .hit   (w_field_hits[FH_PROTO])
  );

  assign w_matched  = &w_field_hits;
  assign matched    = w_matched;
  assign field_hits = w_field_hits;

  // Handshake: valid-only, no ready. in_valid is accepted on every rising edge
  // and reappears as out_valid one cycle later; results hold while idle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_out_valid    <= 1'b0;
      r_matched_q    <= 1'b0;
      r_field_hits_q <= '0;
    end else begin
      r_out_valid <= in_valid;
      if (in_valid) begin
        r_matched_q    <= w_matched;
        r_field_hits_q <= w_field_hits;
      end
    end
  end

  assign out_valid    = r_out_valid;
  assign matched_q    = r_matched_q;
  assign field_hits_q = r_field_hits_q;

endmodule

// File: tb/tb_rule_matcher.sv
// Self-checking bench for rule_matcher: directed cases, asynchronous reset, and
// randomized rules/packets against a field-array reference model.
module tb_rule_matcher;
  import network_pkg::*;

  logic        clk;
  logic        reset;
  rule_s       tb_rule;
  packet_s     tb_pkt;
  logic        tb_in_valid;
  logic        matched;
  logic [4:0]  field_hits;
  logic        out_valid;
  logic        matched_q;
  logic [4:0]  field_hits_q;

  int n_vec  = 0;
  int n_fail = 0;

  logic [6:0]  exp_q[$];
  logic        exp_ov;
  logic        exp_mq;
  logic [4:0]  exp_fhq;

  rule_matcher dut (
    .clk          (clk),
    .reset        (reset),
    .rule         (tb_rule),
    .packet       (tb_pkt),
    .in_valid     (tb_in_valid),
    .matched      (matched),
    .field_hits   (field_hits),
    .out_valid    (out_valid),
    .matched_q    (matched_q),
    .field_hits_q (field_hits_q)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [31:0] wmask(int w);
    logic [31:0] m;
    m = (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
    return m;
  endfunction

  function automatic int fwidth(int i);
    case (i)
      0, 2:    return 32;
      1, 3:    return 16;
      default: return 8;
    endcase
  endfunction

  function automatic logic [4:0] ref_hits(rule_s r, packet_s p);
    longint unsigned v[5];
    longint unsigned lo[5];
    longint unsigned hi[5];
    logic [4:0] h;
    v  = '{p.src.ip, p.src.port, p.dst.ip, p.dst.port, p.protocol};
    lo = '{r.first.src.ip, r.first.src.port, r.first.dst.ip, r.first.dst.port, r.first.protocol};
    hi = '{r.last.src.ip, r.last.src.port, r.last.dst.ip, r.last.dst.port, r.last.protocol};
    for (int i = 0; i < 5; i++) h[i] = (v[i] >= lo[i]) && (v[i] <= hi[i]);
    return h;
  endfunction

  function automatic rule_s wild_rule();
    rule_s r;
    r.first  = '0;
    r.last   = '1;
    r.weight = $urandom;
    return r;
  endfunction

  function automatic packet_s mk_pkt(logic [31:0] sip, logic [15:0] sp,
                                     logic [31:0] dip, logic [15:0] dp, logic [7:0] pr);
    packet_s p;
    p.src.ip = sip; p.src.port = sp; p.dst.ip = dip; p.dst.port = dp; p.protocol = pr;
    return p;
  endfunction

  // ---------------- checker / driver ----------------
  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_regs(string tag);
    check({tag, "/out_valid"},    {31'd0, out_valid}, {31'd0, exp_ov});
    check({tag, "/matched_q"},    {31'd0, matched_q}, {31'd0, exp_mq});
    check({tag, "/field_hits_q"}, {27'd0, field_hits_q}, {27'd0, exp_fhq});
  endtask

  task automatic drive_cycle(rule_s r, packet_s p, logic v, string tag);
    logic [4:0] h;
    logic [6:0] e;
    @(negedge clk);
    tb_rule = r; tb_pkt = p; tb_in_valid = v;
    #1;
    h = ref_hits(r, p);
    check({tag, "/field_hits"}, {27'd0, field_hits}, {27'd0, h});
    check({tag, "/matched"},    {31'd0, matched},    {31'd0, &h});
    exp_q.push_back({v, &h, h});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    exp_ov = e[6];
    if (e[6]) begin
      exp_mq  = e[5];
      exp_fhq = e[4:0];
    end
    check_regs(tag);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rule_s       r;
    packet_s     p;
    packet_s     p_hit;
    packet_s     p_miss;
    logic [31:0] lo[5];
    logic [31:0] hi[5];
    logic [31:0] vv[5];
    logic [31:0] a, b, m;

    reset = 1'b0; tb_in_valid = 1'b0;
    tb_rule = '0; tb_pkt = '0;
    exp_ov = 1'b0; exp_mq = 1'b0; exp_fhq = '0;
    #1;
    check_regs("reset_init");
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b1;

    // 1. full wildcard
    p = mk_pkt(32'h0A00_0001, 16'd80, 32'h0A00_0002, 16'd443, 8'd6);
    drive_cycle(wild_rule(), p, 1'b1, "wildcard");

    // 2. src.ip range with inclusive boundaries
    r = wild_rule();
    r.first.src.ip = 32'h0A00_0000; r.last.src.ip = 32'h0A00_00FF;
    p.src.ip = 32'h0A00_0000; drive_cycle(r, p, 1'b1, "srcip_lo");
    p.src.ip = 32'h0A00_00FF; drive_cycle(r, p, 1'b1, "srcip_hi");
    p.src.ip = 32'h0A00_0100; drive_cycle(r, p, 1'b1, "srcip_above");
    p.src.ip = 32'h09FF_FFFF; drive_cycle(r, p, 1'b1, "srcip_below");

    // 3. single-value protocol
    r = wild_rule();
    r.first.protocol = 8'd6; r.last.protocol = 8'd6;
    p = mk_pkt(32'h0A00_0001, 16'd80, 32'h0A00_0002, 16'd443, 8'd17);
    drive_cycle(r, p, 1'b1, "proto_17");
    p.protocol = 8'd6; drive_cycle(r, p, 1'b1, "proto_6");

    // 4. degenerate dst.port range
    r = wild_rule();
    r.first.dst.port = 16'd100; r.last.dst.port = 16'd50;
    p.dst.port = 16'd75; drive_cycle(r, p, 1'b1, "degenerate");

    // 5. pipeline hit / idle miss / hit: results hold while idle
    r = wild_rule();
    r.first.dst.port = 16'd400; r.last.dst.port = 16'd500;
    p_hit  = mk_pkt(32'h1, 16'h2, 32'h3, 16'd443, 8'd6);
    p_miss = p_hit; p_miss.dst.port = 16'd80;
    drive_cycle(r, p_hit,  1'b1, "pipe_hit0");
    drive_cycle(r, p_miss, 1'b0, "pipe_idle");
    drive_cycle(r, p_hit,  1'b1, "pipe_hit1");

    // 6. asynchronous reset between edges while out_valid is high
    #2 reset = 1'b0;
    #1;
    exp_ov = 1'b0; exp_mq = 1'b0; exp_fhq = '0;
    check_regs("async_reset");
    tb_pkt = p_miss;
    #1;
    check("reset_comb_miss", {31'd0, matched}, {31'd0, &ref_hits(r, p_miss)});
    tb_pkt = p_hit; tb_in_valid = 1'b1;
    #1;
    check("reset_comb_hit", {31'd0, matched}, {31'd0, &ref_hits(r, p_hit)});
    @(posedge clk); #1;
    check_regs("reset_inflight_drop");
    @(negedge clk);
    reset = 1'b1; tb_in_valid = 1'b0;
    @(posedge clk); #1;
    check_regs("reset_release_idle");

    // randomized rules and packets, biased toward range boundaries
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 5; i++) begin
        m = wmask(fwidth(i));
        a = $urandom & m;
        b = $urandom & m;
        case ($urandom_range(0, 4))
          0:       begin lo[i] = 0; hi[i] = m; end
          1:       begin lo[i] = a; hi[i] = a; end
          2:       begin lo[i] = (a < b) ? a : b; hi[i] = (a < b) ? b : a; end
          3:       begin lo[i] = a; hi[i] = b; end
          default: begin lo[i] = a; hi[i] = (a + $urandom_range(0, 3)) & m; end
        endcase
        case ($urandom_range(0, 4))
          0:       vv[i] = lo[i];
          1:       vv[i] = hi[i];
          2:       vv[i] = (lo[i] - 1) & m;
          3:       vv[i] = (hi[i] + 1) & m;
          default: vv[i] = $urandom & m;
        endcase
      end
      r.first = mk_pkt(lo[0], lo[1][15:0], lo[2], lo[3][15:0], lo[4][7:0]);
      r.last  = mk_pkt(hi[0], hi[1][15:0], hi[2], hi[3][15:0], hi[4][7:0]);
      r.weight = $urandom;
      p = mk_pkt(vv[0], vv[1][15:0], vv[2], vv[3][15:0], vv[4][7:0]);
      drive_cycle(r, p, ($urandom_range(0, 9) < 7), "random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
